// File: rtl/memory_read_stage_pkg.sv
// Shared constants, size and state encodings for the ME-stage read engine.
package memory_read_stage_pkg;

    localparam int MRS_LINE_BYTES = 16;
    localparam int MRS_ADDR_W     = 32;
    localparam int MRS_OFF_W      = $clog2(MRS_LINE_BYTES);

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_W = 2'b01,
        SZ_D = 2'b10,
        SZ_Q = 2'b11
    } mrs_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOOK1 = 2'b01,
        LOOK2 = 2'b10,
        DONE  = 2'b11
    } mrs_state_t;

    function automatic int size_bytes(input mrs_size_t sz);
        return 1 << int'(sz);
    endfunction

endpackage

// File: rtl/mrs_byte_extract.sv
// Combinational byte mover: copies `count` bytes of a cache line starting at
// `offset` into the 64-bit result starting at byte `base`; other bytes are zero.
module mrs_byte_extract #(
    parameter int LINE_BYTES = 16
) (
    input  logic [8*LINE_BYTES-1:0]         line,
    input  logic [$clog2(LINE_BYTES)-1:0]   offset,
    input  logic [3:0]                      count,
    input  logic [3:0]                      base,
    output logic [63:0]                     data
);

    localparam int OFF_W = $clog2(LINE_BYTES);

    logic [OFF_W-1:0] src;

    always_comb begin
        data = '0;
        src  = '0;
        for (int i = 0; i < 8; i++) begin
            if (i >= int'(base) && i < int'(base) + int'(count)) begin
                src = offset + OFF_W'(i - int'(base));
                data[8*i +: 8] = line[8*src +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_read_stage.sv
// ME-stage read engine: line-granular cache reads, split-line merge, EX handoff.
// Optional one-entry line buffer enabled by defining MRS_LINE_BUF_EN.
module memory_read_stage
    import memory_read_stage_pkg::*;
#(
    parameter int LINE_BYTES = MRS_LINE_BYTES,
    parameter int ADDR_W     = MRS_ADDR_W
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      V,
    input  logic                      MEM_RD,
    input  logic [ADDR_W-1:0]         RD_ADDR,
    input  logic [1:0]                DATA_SIZE,
    input  logic                      FLUSH,
    input  logic                      EX_STALL,
    output logic                      DC_REQ,
    output logic [ADDR_W-1:0]         DC_ADDR,
    input  logic                      DC_READY,
    input  logic [8*LINE_BYTES-1:0]   DC_DATA,
    input  logic                      WR_INV_V,
    input  logic [ADDR_W-1:0]         WR_INV_ADDR,
    output logic                      STALL_OUT,
    output logic                      V_OUT,
    output logic [63:0]               RD_DATA_OUT
);

    // state | meaning
    // IDLE  | no op held, ready to accept
    // LOOK1 | waiting for the line holding the first byte
    // LOOK2 | waiting for the following line (split read)
    // DONE  | result valid to EX, held while EX_STALL

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int TAG_W = ADDR_W - OFF_W;

    mrs_state_t              state;
    logic [ADDR_W-1:0]       addr;
    mrs_size_t               size;
    logic [63:0]             acc;

    logic [OFF_W-1:0]        off;
    logic [TAG_W-1:0]        tag1, tag2, look_tag;
    logic                    looking, hit, rdy, split;
    int                      n_bytes, room;
    logic [3:0]              first_cnt, second_cnt;
    logic [8*LINE_BYTES-1:0] line_src;
    logic [OFF_W-1:0]        ext_off;
    logic [3:0]              ext_cnt, ext_base;
    logic [63:0]             ext_data;

    assign off      = addr[OFF_W-1:0];
    assign tag1     = addr[ADDR_W-1:OFF_W];
    assign tag2     = tag1 + TAG_W'(1);   // wraps past the top of the address space
    assign looking  = (state == LOOK1) || (state == LOOK2);
    assign look_tag = (state == LOOK2) ? tag2 : tag1;

    assign DC_REQ    = looking && !hit;
    assign DC_ADDR   = looking ? {look_tag, {OFF_W{1'b0}}} : '0;
    assign STALL_OUT = looking || ((state == DONE) && EX_STALL);
    assign rdy       = (DC_REQ && DC_READY) || hit;

    always_comb begin
        n_bytes    = size_bytes(size);
        room       = LINE_BYTES - int'(off);
        split      = n_bytes > room;
        first_cnt  = split ? 4'(room) : 4'(n_bytes);
        second_cnt = 4'(n_bytes) - first_cnt;
    end

    assign ext_off  = (state == LOOK2) ? '0 : off;
    assign ext_cnt  = (state == LOOK2) ? second_cnt : first_cnt;
    assign ext_base = (state == LOOK2) ? first_cnt : 4'd0;

`ifdef MRS_LINE_BUF_EN
    logic                    lb_valid;
    logic [TAG_W-1:0]        lb_tag;
    logic [8*LINE_BYTES-1:0] lb_data;
    logic [TAG_W-1:0]        inv_tag;
    logic                    fill;

    assign inv_tag  = WR_INV_ADDR[ADDR_W-1:OFF_W];
    // a store to the buffered line in the same cycle must not be bypassed
    assign hit      = looking && lb_valid && (lb_tag == look_tag)
                      && !(WR_INV_V && (inv_tag == lb_tag));
    assign fill     = DC_REQ && DC_READY;
    assign line_src = hit ? lb_data : DC_DATA;

    always_ff @(posedge CLK) begin
        if (!RST || FLUSH) begin
            lb_valid <= 1'b0;
        end else if (fill) begin
            lb_valid <= !(WR_INV_V && (inv_tag == look_tag));
            lb_tag   <= look_tag;
            lb_data  <= DC_DATA;
        end else if (WR_INV_V && (inv_tag == lb_tag)) begin
            lb_valid <= 1'b0;
        end
    end
`else
    logic unused_inv;

    assign hit        = 1'b0;
    assign line_src   = DC_DATA;
    assign unused_inv = ^{WR_INV_V, WR_INV_ADDR};
`endif

    mrs_byte_extract #(.LINE_BYTES(LINE_BYTES)) u_extract (
        .line   (line_src),
        .offset (ext_off),
        .count  (ext_cnt),
        .base   (ext_base),
        .data   (ext_data)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            addr        <= '0;
            size        <= SZ_B;
            acc         <= '0;
            V_OUT       <= 1'b0;
            RD_DATA_OUT <= '0;
        end else if (FLUSH) begin
            state       <= IDLE;
            V_OUT       <= 1'b0;
            RD_DATA_OUT <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (state == IDLE || !EX_STALL) begin
                        if (V) begin
                            addr <= RD_ADDR;
                            size <= mrs_size_t'(DATA_SIZE);
                            if (MEM_RD) begin
                                state <= LOOK1;
                                V_OUT <= 1'b0;
                            end else begin
                                state       <= DONE;
                                V_OUT       <= 1'b1;
                                RD_DATA_OUT <= '0;
                            end
                        end else begin
                            state <= IDLE;
                            V_OUT <= 1'b0;
                        end
                    end
                end
                LOOK1: begin
                    if (rdy) begin
                        acc <= ext_data;
                        if (split) begin
                            state <= LOOK2;
                        end else begin
                            state       <= DONE;
                            V_OUT       <= 1'b1;
                            RD_DATA_OUT <= ext_data;
                        end
                    end
                end
                LOOK2: begin
                    if (rdy) begin
                        state       <= DONE;
                        V_OUT       <= 1'b1;
                        RD_DATA_OUT <= acc | ext_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_read_stage.sv
// Directed plus randomized bench for memory_read_stage against a byte-addressed memory model.
module tb_memory_read_stage;

    localparam int LB = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          V = 1'b0;
    logic          MEM_RD = 1'b0;
    logic [31:0]   RD_ADDR = '0;
    logic [1:0]    DATA_SIZE = '0;
    logic          FLUSH = 1'b0;
    logic          EX_STALL = 1'b0;
    logic          DC_READY = 1'b0;
    logic [8*LB-1:0] DC_DATA = '0;
    logic          WR_INV_V = 1'b0;
    logic [31:0]   WR_INV_ADDR = '0;
    logic          DC_REQ;
    logic [31:0]   DC_ADDR;
    logic          STALL_OUT;
    logic          V_OUT;
    logic [63:0]   RD_DATA_OUT;

    memory_read_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .V           (V),
        .MEM_RD      (MEM_RD),
        .RD_ADDR     (RD_ADDR),
        .DATA_SIZE   (DATA_SIZE),
        .FLUSH       (FLUSH),
        .EX_STALL    (EX_STALL),
        .DC_REQ      (DC_REQ),
        .DC_ADDR     (DC_ADDR),
        .DC_READY    (DC_READY),
        .DC_DATA     (DC_DATA),
        .WR_INV_V    (WR_INV_V),
        .WR_INV_ADDR (WR_INV_ADDR),
        .STALL_OUT   (STALL_OUT),
        .V_OUT       (V_OUT),
        .RD_DATA_OUT (RD_DATA_OUT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int passed = 0;
    int nreq = 0;
    logic [7:0] mem_ovr [logic [31:0]];
    logic [63:0] exp_q [$];
    logic        held_v = 1'b0;
    logic [63:0] held_data = '0;
    logic        ag_v, ag_rd;
    logic [31:0] ag_addr;
    logic [1:0]  ag_sz;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return 8'((a * 32'd37) ^ (a >> 9) ^ 32'h5A);
    endfunction

    function automatic logic [8*LB-1:0] line_data(input logic [31:0] la);
        logic [8*LB-1:0] d;
        for (int i = 0; i < LB; i++) d[8*i +: 8] = mem_byte(la + 32'(i));
        return d;
    endfunction

    // n consecutive bytes from memory, little-endian, address wraps at 2^32
    function automatic logic [63:0] exp_read(input logic [31:0] a, input logic [1:0] sz, input logic rd);
        logic [63:0] r;
        r = '0;
        if (!rd) return r;
        for (int k = 0; k < (1 << sz); k++) r[8*k +: 8] = mem_byte(a + 32'(k));
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // called at a negedge with inputs set; the cache answers with the addressed line
    task automatic step();
        #1;
        DC_DATA = line_data({DC_ADDR[31:4], 4'h0});
        if (DC_REQ && DC_READY) nreq++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic start_test();
        V = 1'b0; FLUSH = 1'b1; EX_STALL = 1'b0; DC_READY = 1'b1; WR_INV_V = 1'b0;
        step();
        FLUSH = 1'b0;
        nreq = 0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic rd);
        V = 1'b1; MEM_RD = rd; RD_ADDR = a; DATA_SIZE = sz;
        step();
        V = 1'b0;
    endtask

    task automatic run_single(input string tag, input logic [31:0] a, input logic [1:0] sz);
        issue(a, sz, 1'b1);
        for (int i = 0; i < 8 && !V_OUT; i++) step();
        check({tag, "_v"}, V_OUT, 1);
        check({tag, "_data"}, RD_DATA_OUT, exp_read(a, sz, 1'b1));
        step();
    endtask

    task automatic consume();
        if (held_v) begin
            check("hold_v", V_OUT, 1);
            check("hold_data", RD_DATA_OUT, held_data);
        end
        if (V_OUT && !EX_STALL) begin
            if (exp_q.size() == 0) check("spurious_v", V_OUT, 0);
            else check("rand_data", RD_DATA_OUT, exp_q.pop_front());
        end
        held_v = V_OUT && EX_STALL;
        held_data = RD_DATA_OUT;
    endtask

    task automatic new_op();
        logic [31:0] base;
        ag_v  = ($urandom_range(3) != 0);
        ag_rd = ($urandom_range(4) != 0);
        ag_sz = 2'($urandom_range(3));
        case ($urandom_range(3))
            0: base = 32'h0000_1000;
            1: base = 32'h0000_2000;
            2: base = 32'hFFFF_FFF0;
            default: base = $urandom & 32'hFFFF_FFF0;
        endcase
        ag_addr = base | 32'($urandom_range(15));
    endtask

    initial begin
        mem_ovr[32'h1004] = 8'hAA;
        mem_ovr[32'h1005] = 8'hBB;
        mem_ovr[32'h1006] = 8'hCC;
        mem_ovr[32'h1007] = 8'hDD;

        // reset state
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        check("rst_v", V_OUT, 0);
        check("rst_data", RD_DATA_OUT, 0);
        check("rst_req", DC_REQ, 0);
        check("rst_addr", DC_ADDR, 0);
        check("rst_stall", STALL_OUT, 0);

        // aligned dword
        start_test();
        issue(32'h1004, 2'b10, 1'b1);
        check("al_req", DC_REQ, 1);
        check("al_addr", DC_ADDR, 32'h1000);
        check("al_stall", STALL_OUT, 1);
        check("al_v1", V_OUT, 0);
        step();
        check("al_v2", V_OUT, 1);
        check("al_data", RD_DATA_OUT, 64'h0000_0000_DDCC_BBAA);
        check("al_nreq", nreq, 1);
        step();

        // split qword, then pass-through accepted straight out of DONE
        start_test();
        issue(32'h100D, 2'b11, 1'b1);
        check("sp_addr1", DC_ADDR, 32'h1000);
        check("sp_stall1", STALL_OUT, 1);
        step();
        check("sp_addr2", DC_ADDR, 32'h1010);
        check("sp_stall2", STALL_OUT, 1);
        check("sp_v2", V_OUT, 0);
        step();
        check("sp_v3", V_OUT, 1);
        check("sp_data", RD_DATA_OUT, exp_read(32'h100D, 2'b11, 1'b1));
        check("sp_nreq", nreq, 2);
        check("sp_stall3", STALL_OUT, 0);
        issue(32'h2222, 2'b11, 1'b0);
        check("pt_v", V_OUT, 1);
        check("pt_data", RD_DATA_OUT, 0);
        check("pt_nreq", nreq, 2);
        step();

        // address wrap
        start_test();
        issue(32'hFFFF_FFFE, 2'b10, 1'b1);
        check("wr_addr1", DC_ADDR, 32'hFFFF_FFF0);
        step();
        check("wr_addr2", DC_ADDR, 32'h0000_0000);
        check("wr_req2", DC_REQ, 1);
        step();
        check("wr_v", V_OUT, 1);
        check("wr_data", RD_DATA_OUT, exp_read(32'hFFFF_FFFE, 2'b10, 1'b1));
        step();

        // back-pressure with a queued op
        start_test();
        issue(32'h3001, 2'b01, 1'b1);
        step();
        V = 1'b1; MEM_RD = 1'b1; RD_ADDR = 32'h3100; DATA_SIZE = 2'b00;
        for (int i = 0; i < 3; i++) begin
            EX_STALL = 1'b1;
            #1;
            check("bp_v", V_OUT, 1);
            check("bp_data", RD_DATA_OUT, exp_read(32'h3001, 2'b01, 1'b1));
            check("bp_stall", STALL_OUT, 1);
            step();
        end
        EX_STALL = 1'b0;
        #1;
        check("bp_rel_v", V_OUT, 1);
        check("bp_rel_stall", STALL_OUT, 0);
        step();
        V = 1'b0;
        check("bp_next_addr", DC_ADDR, 32'h3100);
        check("bp_next_v", V_OUT, 0);
        step();
        check("bp_b_v", V_OUT, 1);
        check("bp_b_data", RD_DATA_OUT, exp_read(32'h3100, 2'b00, 1'b1));
        step();

        // flush in LOOK2 with a same-cycle DC_READY
        start_test();
        issue(32'h10FC, 2'b11, 1'b1);
        step();
        check("fl_addr2", DC_ADDR, 32'h1100);
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        check("fl_v", V_OUT, 0);
        check("fl_req", DC_REQ, 0);
        check("fl_stall", STALL_OUT, 0);
        step();
        check("fl_v_after", V_OUT, 0);

        // reset in LOOK1
        start_test();
        issue(32'h4000, 2'b00, 1'b1);
        RST = 1'b0;
        step();
        RST = 1'b1;
        check("rl_v", V_OUT, 0);
        check("rl_data", RD_DATA_OUT, 0);
        check("rl_req", DC_REQ, 0);
        check("rl_addr", DC_ADDR, 0);
        check("rl_stall", STALL_OUT, 0);

`ifdef MRS_LINE_BUF_EN
        start_test();
        run_single("lb_a", 32'h2004, 2'b00);
        check("lb_a_nreq", nreq, 1);
        run_single("lb_b", 32'h2008, 2'b00);
        check("lb_hit_nreq", nreq, 1);
        WR_INV_V = 1'b1; WR_INV_ADDR = 32'h2008;
        step();
        WR_INV_V = 1'b0;
        run_single("lb_c", 32'h2000, 2'b00);
        check("lb_inv_nreq", nreq, 2);
`endif

        // randomized stream with random back-pressure and cache latency
        start_test();
        held_v = 1'b0;
        new_op();
        for (int c = 0; c < 800; c++) begin
            EX_STALL = ($urandom_range(3) == 0);
            consume();
            V = ag_v; MEM_RD = ag_rd; RD_ADDR = ag_addr; DATA_SIZE = ag_sz;
            DC_READY = ($urandom_range(9) < 7);
            #1;
            if (!STALL_OUT) begin
                if (ag_v) exp_q.push_back(exp_read(ag_addr, ag_sz, ag_rd));
                new_op();
            end
            step();
        end
        V = 1'b0;
        for (int c = 0; c < 60 && (exp_q.size() != 0 || V_OUT); c++) begin
            EX_STALL = ($urandom_range(3) == 0);
            consume();
            DC_READY = 1'b1;
            step();
        end
        check("drain_left", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
